// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer with downstream reset release
// Optional lock-loss counter enabled by defining LOCK_LOSS_CNT_EN.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 24,
  parameter int LOCK_TIMEOUT  = 24000,
  parameter int STABLE_CYCLES = 240,
  parameter int MAX_RETRY     = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       rst_out_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST,
    S_WAIT,
    S_STAB,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sync1;
  logic          lock_s;
  logic [3:0]    retry_next;

  assign retry_next = retry_cnt + 4'd1;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= S_RST;
      cnt       <= '0;
      sync1     <= 1'b0;
      lock_s    <= 1'b0;
      pll_rst   <= 1'b1;
      rst_out_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= 4'd0;
`ifdef LOCK_LOSS_CNT_EN
      loss_cnt  <= 8'd0;
`endif
    end else begin
      // raw pll_lock is only ever seen through this synchronizer
      sync1  <= pll_lock;
      lock_s <= sync1;
      case (state)
        S_RST: begin
          if (cnt == RST_LAST) begin
            state   <= S_WAIT;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (lock_s) begin
            state <= S_STAB;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            cnt       <= '0;
            retry_cnt <= retry_next;
            if (retry_next == RETRY_LIM) begin
              state <= S_FAIL;
              fail  <= 1'b1;
            end else begin
              state   <= S_RST;
              pll_rst <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STAB: begin
          // a dropout sends us back to waiting without charging a retry
          if (!lock_s) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else if (cnt == STAB_LAST) begin
            state     <= S_RUN;
            cnt       <= '0;
            rst_out_n <= 1'b1;
            ready     <= 1'b1;
            retry_cnt <= 4'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state     <= S_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            rst_out_n <= 1'b0;
            ready     <= 1'b0;
`ifdef LOCK_LOSS_CNT_EN
            if (loss_cnt != 8'hff) loss_cnt <= loss_cnt + 8'd1;
`endif
          end
        end
        S_FAIL: begin
          if (retry_req) begin
            state     <= S_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            fail      <= 1'b0;
            retry_cnt <= 4'd0;
          end
        end
        default: begin
          state     <= S_RST;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          rst_out_n <= 1'b0;
          ready     <= 1'b0;
          fail      <= 1'b0;
        end
      endcase
    end
  end

endmodule
